regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter NWR, default 2, number of write ports (1..2).
REQ-005 SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads 0 and ignores writes.
REQ-006 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-007 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-008 SHALL have port we, input, NWR, per-port write enable.
REQ-009 SHALL have port waddr, input, NWR*ADDR_W, packed write addresses, port 0 in LSBs.
REQ-010 SHALL have port wdata, input, NWR*DATA_W, packed write data.
REQ-011 SHALL have port re, input, NRD, per-port read enable.
REQ-012 SHALL have port raddr, input, NRD*ADDR_W, packed read addresses.
REQ-013 SHALL have port rdata, output, NRD*DATA_W, packed read data.
REQ-014 SHALL have port rbusy, output, NRD, read operand has an outstanding producer (stall request).
REQ-015 SHALL have port issue_v, input, 1, marks issue_addr as pending (producer issued).
REQ-016 SHALL have port issue_addr, input, ADDR_W, destination register of issued producer.
REQ-017 SHALL have port flush, input, 1, clears all pending bits.

Function
REQ-018 SHALL write wdata slice k to regs[waddr slice k] at rising edge when we[k]=1, rst=0, and not (ZERO_REG and address 0).
REQ-019 SHALL, when two write ports target the same address in one cycle, store the higher-index port's data.
REQ-020 SHALL produce rdata slice i combinationally with priority: rst=1 -> 0; ZERO_REG and raddr=0 -> 0; re[i]=0 -> 0; address matches an enabled write port -> that wdata (highest matching index); else regs[raddr].
REQ-021 SHALL therefore give zero-latency write-to-read bypass; data is in the array from the following cycle.
REQ-022 SHALL keep one pending bit per register; rising edge with issue_v=1 sets pending[issue_addr].
REQ-023 SHALL clear pending[waddr slice k] at rising edge for each enabled write port k.
REQ-024 SHALL, when issue and write hit the same address in one cycle, leave the bit set (new producer wins).
REQ-025 SHALL, on flush=1, clear all pending bits at the edge; flush overrides a same-cycle issue.
REQ-026 SHALL never set the pending bit for address 0 when ZERO_REG=1.
REQ-027 SHALL drive rbusy[i] = re[i] and pending[raddr i] and no enabled write port matches raddr i in this cycle; 0 when rst=1 or address is hardwired zero.

Reset
REQ-028 SHALL, on rising edge with rst=1, clear every register to 0 and every pending bit to 0; writes, issues and flush are ignored that cycle.
REQ-029 SHALL hold rdata and rbusy at 0 for as long as rst=1, including reset asserted mid-operation.

Structure
REQ-030 SHALL place default DATA_W/ADDR_W/NRD/NWR values and the enable/reset level constants in shared package regfile_pkg.
REQ-031 SHALL implement one read port (zero check, bypass mux, busy logic) as sub-module regfile_rdport, instantiated NRD times via generate.

Verification
REQ-032 SHALL cover: reset, then write r5=0x1234 via port 0 -> same-cycle read r5 returns 0x1234 (bypass), next cycle 0x1234 from array.
REQ-033 SHALL cover: both ports write r7 (port0=0xAAAA, port1=0x5555) -> bypass and subsequent read both return 0x5555.
REQ-034 SHALL cover: write r0=0xFFFF, issue r0 -> read r0 returns 0, rbusy 0.
REQ-035 SHALL cover: issue r3, next cycle read r3 -> rbusy=1; cycle with write r3 -> rbusy=0, rdata=wdata; issue+write r3 same cycle -> rbusy=1 next cycle.
REQ-036 SHALL cover: issue r9 and r10, flush -> rbusy 0 on both; rst mid-sequence after writing r4=0x77 -> r4 reads 0 after reset.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file: default geometry
// and the active levels used for enables and reset.
package regfile_pkg;

    localparam int REGFILE_DATA_W = 32;
    localparam int REGFILE_ADDR_W = 5;
    localparam int REGFILE_NRD    = 2;
    localparam int REGFILE_NWR    = 2;

    localparam logic EN_ACTIVE  = 1'b1;
    localparam logic RST_ACTIVE = 1'b1;

    // True when an address is the hardwired-zero register for this build.
    function automatic logic is_zero_reg(input int zero_reg, input logic [31:0] addr);
        return (zero_reg != 0) && (addr == 32'd0);
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One read port: hardwired-zero check, same-cycle write bypass and
// operand-busy (stall request) generation. Purely combinational.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = REGFILE_DATA_W,
    parameter int ADDR_W   = REGFILE_ADDR_W,
    parameter int NWR      = REGFILE_NWR,
    parameter int ZERO_REG = 1
) (
    input  logic                    rst,
    input  logic                    re,
    input  logic [ADDR_W-1:0]       raddr,
    input  logic [NWR-1:0]          we,
    input  logic [NWR*ADDR_W-1:0]   waddr,
    input  logic [NWR*DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]       arr_data,
    input  logic                    pend_bit,
    output logic [DATA_W-1:0]       rdata,
    output logic                    rbusy
);

    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;
    logic [31:0]       raddr_ext;

    assign raddr_ext = 32'(raddr);

    // Bypass search: the highest-index enabled write port on this address wins.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        for (int k = 0; k < NWR; k++) begin
            if (we[k] == EN_ACTIVE && waddr[k*ADDR_W +: ADDR_W] == raddr) begin
                byp_hit  = 1'b1;
                byp_data = wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // Output priority: reset, hardwired zero, disabled port, bypass, array.
    // A bypassed operand is never busy: its producer is writing right now.
    always_comb begin
        rdata = '0;
        rbusy = 1'b0;
        if (rst == RST_ACTIVE) begin
            rdata = '0;
        end else if (is_zero_reg(ZERO_REG, raddr_ext)) begin
            rdata = '0;
        end else if (re != EN_ACTIVE) begin
            rdata = '0;
        end else if (byp_hit) begin
            rdata = byp_data;
        end else begin
            rdata = arr_data;
            rbusy = pend_bit;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-ported register file with a per-register pending (scoreboard) bit.
// Writes land at the rising edge and are bypassed to same-cycle reads; an
// issued producer marks its destination pending until a write retires it.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = REGFILE_DATA_W,
    parameter int ADDR_W   = REGFILE_ADDR_W,
    parameter int NRD      = REGFILE_NRD,
    parameter int NWR      = REGFILE_NWR,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*ADDR_W-1:0] waddr,
    input  logic [NWR*DATA_W-1:0] wdata,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic                  issue_v,
    input  logic [ADDR_W-1:0]     issue_addr,
    input  logic                  flush
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;

    // Register array: ports applied in index order so the higher port wins.
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            for (int a = 0; a < DEPTH; a++) begin
                regs_q[a] <= '0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (we[k] == EN_ACTIVE &&
                    !is_zero_reg(ZERO_REG, 32'(waddr[k*ADDR_W +: ADDR_W]))) begin
                    regs_q[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Pending next state: writes retire, a new issue wins over a same-cycle
    // write, flush wins over everything, and the zero register never pends.
    always_comb begin
        pend_d = pend_q;
        for (int k = 0; k < NWR; k++) begin
            if (we[k] == EN_ACTIVE) begin
                pend_d[waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (issue_v == EN_ACTIVE) begin
            pend_d[issue_addr] = 1'b1;
        end
        if (flush == EN_ACTIVE) begin
            pend_d = '0;
        end
        if (ZERO_REG != 0) begin
            pend_d[0] = 1'b0;
        end
    end

    // Pending register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = raddr[i*ADDR_W +: ADDR_W];

        regfile_rdport #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NWR      (NWR),
            .ZERO_REG (ZERO_REG)
        ) u_rdport (
            .rst      (rst),
            .re       (re[i]),
            .raddr    (ra),
            .we       (we),
            .waddr    (waddr),
            .wdata    (wdata),
            .arr_data (regs_q[ra]),
            .pend_bit (pend_q[ra]),
            .rdata    (rdata[i*DATA_W +: DATA_W]),
            .rbusy    (rbusy[i])
        );
    end

endmodule
